// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer and memory-port arbiter in front of a
// synchronous instruction memory with one cycle of read latency.
// Owns the PC, presents fetched instructions to IF/ID, holds them across
// stalls, squashes them on redirect, and lends idle memory slots to a
// debug/loader read port.
// Optional build macro: DBG_STARVE_GUARD_EN lets a debug request that has
// waited DBG_MAX_WAIT cycles steal one fetch slot while running.
module imem_fetch_ctrl #(
  parameter int          ADDR_W       = 30,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int          DBG_MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              if_stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_q,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state, nstate;
  logic [31:0] pc;             // next PC to be issued
  logic        issue;          // a fetch goes to memory this cycle
  logic [31:0] issue_pc;
  logic        steal_ok;       // starvation guard wants this RUN slot

  // stage p1: memory is returning data for what was issued last cycle
  logic        fetch_vld_p1;
  logic [31:0] fetch_pc_p1;
  logic [31:0] hold_inst_p1;
  logic        dbg_vld_p1;
  logic [31:0] dbg_rdata_p1;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{redirect_pc[1:0], dbg_addr};

`ifdef DBG_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(DBG_MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign steal_ok = dbg_req && (wait_cnt >= WAIT_W'(DBG_MAX_WAIT - 1));

  // Count RUN cycles a debug request has been left waiting; saturates.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (!dbg_req || dbg_gnt)
      wait_cnt <= '0;
    else if (state == RUN && wait_cnt < WAIT_W'(DBG_MAX_WAIT))
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic unused_guard;
  assign unused_guard = (DBG_MAX_WAIT > 0);
  assign steal_ok     = 1'b0;
`endif

  // A redirect squashes whatever is presented this cycle.
  assign if_valid  = (fetch_vld_p1 || state == HOLD) && !redirect_valid;
  assign if_pc     = fetch_pc_p1;
  assign if_inst   = !if_valid    ? NOP_INST :
                     fetch_vld_p1 ? mem_q    : hold_inst_p1;
  assign dbg_rvalid = dbg_vld_p1;
  assign dbg_rdata  = dbg_vld_p1 ? mem_q : dbg_rdata_p1;

  // Next state, fetch issue and memory-port arbitration.
  always_comb begin
    nstate   = state;
    issue    = 1'b0;
    issue_pc = pc;
    dbg_gnt  = 1'b0;
    if (redirect_valid) begin
      issue_pc = {redirect_pc[31:2], 2'b00};
      if (state != IDLE || fetch_en) begin
        issue  = 1'b1;
        nstate = RUN;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (dbg_req) begin
            dbg_gnt = 1'b1;
          end else if (fetch_en) begin
            issue  = 1'b1;
            nstate = RUN;
          end
        end
        RUN: begin
          if (if_valid && if_stall) begin
            dbg_gnt = steal_ok;
            nstate  = HOLD;
          end else if (!fetch_en) begin
            nstate = IDLE;
          end else if (steal_ok) begin
            dbg_gnt = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
        HOLD: begin
          dbg_gnt = dbg_req;
          if (!if_stall) begin
            issue  = fetch_en && !dbg_req;
            nstate = fetch_en ? RUN : IDLE;
          end
        end
        default: nstate = IDLE;
      endcase
    end
    if (redirect_valid || !dbg_gnt)
      mem_addr = issue_pc[ADDR_W+1:2];
    else
      mem_addr = dbg_addr[ADDR_W+1:2];
  end

  // State, PC and p1 pipeline registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_vld_p1 <= 1'b0;
      fetch_pc_p1  <= RESET_PC;
      hold_inst_p1 <= NOP_INST;
      dbg_vld_p1   <= 1'b0;
      dbg_rdata_p1 <= '0;
    end else begin
      state        <= nstate;
      fetch_vld_p1 <= issue;
      dbg_vld_p1   <= dbg_gnt;
      if (issue) begin
        pc          <= issue_pc + 32'd4;
        fetch_pc_p1 <= issue_pc;
      end else if (redirect_valid) begin
        pc <= issue_pc;
      end
      if (fetch_vld_p1)
        hold_inst_p1 <= mem_q;
      if (dbg_vld_p1)
        dbg_rdata_p1 <= mem_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: stimulus queues expected
// instructions and debug reads; monitors compare on if_valid / dbg_rvalid.
module tb_imem_fetch_ctrl;

  logic        clock = 1'b0;
  logic        rst;
  logic        fetch_en, if_stall, redirect_valid, dbg_req;
  logic [31:0] redirect_pc, dbg_addr, mem_q;
  logic [29:0] mem_addr;
  logic        if_valid, dbg_gnt, dbg_rvalid;
  logic [31:0] if_pc, if_inst, dbg_rdata;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] dbg_q[$];

  always #5 clock = ~clock;

  imem_fetch_ctrl dut (
    .clock(clock), .rst(rst), .fetch_en(fetch_en), .if_stall(if_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_q(mem_q), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
  );

  // memory: word i holds 0xA000_0000 + i, one cycle read latency
  always @(posedge clock) mem_q <= 32'hA000_0000 + {2'b00, mem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, 32'hA000_0000 + {2'b00, pc[31:2]}};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (if_valid && if_pc == pc) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_pc: pc %h never presented within 60 cycles", pc);
    end
  endtask

  // instruction / debug monitors
  always @(negedge clock) begin
    if (!rst) begin
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL if_unexpected: got pc %h inst %h expected nothing", if_pc, if_inst);
        end else begin
          chk("if_pc", if_pc, exp_q[0][63:32]);
          chk("if_inst", if_inst, exp_q[0][31:0]);
          if (!if_stall) void'(exp_q.pop_front());
        end
      end
      if (dbg_rvalid) begin
        if (dbg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dbg_unexpected: got %h expected nothing", dbg_rdata);
        end else begin
          chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic seen;
    rst = 1'b1; fetch_en = 1'b0; if_stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; dbg_req = 1'b0; dbg_addr = '0;
    repeat (2) step();
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h13);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);

    // 1: sequential fetch from reset, 2: 3-cycle stall at pc 8
    for (int i = 0; i < 5; i++) exp_q.push_back(ent(32'(i * 4)));
    rst = 1'b0; fetch_en = 1'b1;
    #1;
    chk("first_cycle_invalid", {31'd0, if_valid}, 32'd0);
    step();
    chk("valid_cycle2", {31'd0, if_valid}, 32'd1);
    wait_pc(32'h8);
    if_stall = 1'b1;
    step(); step();
    chk("hold_inst", if_inst, 32'hA000_0002);
    step();
    if_stall = 1'b0;

    // 3: redirect to 4 at pc 0x14, then to 0x41 while pc 4 is presented
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'h40 + 32'(i * 4)));
    wait_pc(32'h14);
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    #1;
    chk("squash_14", {31'd0, if_valid}, 32'd0);
    step();
    redirect_pc = 32'h41;
    #1;
    chk("squash_4", {31'd0, if_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;

    // 4: debug read during HOLD
    wait_pc(32'h48);
    if_stall = 1'b1;
    step();
    dbg_req = 1'b1; dbg_addr = 32'h14;
    dbg_q.push_back(32'hA000_0005);
    #1;
    chk("gnt_in_hold", {31'd0, dbg_gnt}, 32'd1);
    step();
    dbg_req = 1'b0;
    chk("dbg_rvalid_pulse", {31'd0, dbg_rvalid}, 32'd1);
    step();
    chk("dbg_rvalid_drop", {31'd0, dbg_rvalid}, 32'd0);
    chk("dbg_rdata_held", dbg_rdata, 32'hA000_0005);
    if_stall = 1'b0;
    wait_pc(32'h4C);
    fetch_en = 1'b0;
    step();
    chk("idle_invalid", {31'd0, if_valid}, 32'd0);

    // 5: redirect latched in IDLE beats debug, then wrap at 0xFFFF_FFFC
    dbg_req = 1'b1; dbg_addr = 32'h8;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("no_gnt_with_redirect", {31'd0, dbg_gnt}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("gnt_retry_idle", {31'd0, dbg_gnt}, 32'd1);
    dbg_q.push_back(32'hA000_0002);
    exp_q.push_back(ent(32'hFFFF_FFFC));
    for (int i = 0; i <= 24; i++) exp_q.push_back(ent(32'(i * 4)));
    step();
    dbg_req = 1'b0; fetch_en = 1'b1;

    // 6: debug request while running
    wait_pc(32'h4);
    dbg_req = 1'b1; dbg_addr = 32'h20;
    dbg_q.push_back(32'hA000_0008);
    #1;
`ifdef DBG_STARVE_GUARD_EN
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      if (dbg_gnt) begin
        cyc = i;
        break;
      end
      step();
    end
    chk("guard_grant_cycle", 32'(cyc), 32'd8);
    step();
    dbg_req = 1'b0;
    #1;
    chk("guard_bubble", {31'd0, if_valid}, 32'd0);
`else
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (dbg_gnt) seen = 1'b1;
      step();
    end
    chk("no_grant_in_run", {31'd0, seen}, 32'd0);
    if_stall = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (dbg_gnt) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("grant_after_stall", {31'd0, seen}, 32'd1);
    step();
    dbg_req = 1'b0; if_stall = 1'b0;
`endif
    wait_pc(32'h60);
    fetch_en = 1'b0;
    repeat (3) step();
    chk("if_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);

    // reset with a debug read in flight
    dbg_req = 1'b1; dbg_addr = 32'h30;
    #1;
    chk("gnt_before_reset", {31'd0, dbg_gnt}, 32'd1);
    #2;
    rst = 1'b1;
    #2;
    dbg_req = 1'b0;
    chk("mid_rst_if_pc", if_pc, 32'h0);
    chk("mid_rst_if_inst", if_inst, 32'h13);
    step();
    chk("mid_rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("mid_rst_rdata", dbg_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
